// File: rtl/wr_ctrl_pkg.sv
// Shared state type and burst sizing helper for the Avalon-MM burst write controller.
// Latency: none; declarations and a combinational function only.
// Backpressure: not applicable.
package wr_ctrl_pkg;

  localparam int BURSTCOUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Beats for the next burst. The result is the smallest of three limits:
  //   - the burst cap;
  //   - the words still owed for the packet;
  //   - the words left before the next max_burst-aligned word boundary.
  // max_burst must be a power of two, so masking with (max_burst-1) is the modulo.
  function automatic logic [BURSTCOUNT_W-1:0] burst_len(
    input logic [63:0] remaining,
    input logic [63:0] word_addr,
    input logic [63:0] max_burst
  );
    logic [63:0] to_bnd;
    logic [63:0] len;
    to_bnd = max_burst - (word_addr & (max_burst - 64'd1));
    len    = max_burst;
    if (to_bnd < len) len = to_bnd;
    if (remaining < len) len = remaining;
    return len[BURSTCOUNT_W-1:0];
  endfunction

endpackage

// File: rtl/avmm_burst_wr_ctrl.sv
// Avalon-MM burst write master draining a show-ahead FIFO into [pkt_begin, pkt_end).
// Latency: request edge N -> CALC in N+1 -> first write in N+2; one beat per cycle, one CALC cycle between bursts.
// Backpressure: waitrequest freezes all outputs and suppresses fifo_rd; a burst only starts once fifo_usedw covers it.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_ctrl               level request, held for the whole transfer
//   pkt_begin, pkt_end    byte range (end exclusive), latched when the request is taken
//   fifo_out, fifo_usedw  show-ahead FIFO head word and fill level
//   fifo_rd               pop strobe, one per accepted beat
//   wr_ctrl_rdy, busy     transfer complete (DONE) / not IDLE
//   address, burstcount   burst start byte address and beat count, held for the burst
//   writedata, write      Avalon write data and strobe
//   waitrequest           Avalon slave stall
module avmm_burst_wr_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int USEDW_W   = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_ctrl,
  input  logic [ADDR_W-1:0]       pkt_begin,
  input  logic [ADDR_W-1:0]       pkt_end,
  input  logic [DATA_W-1:0]       fifo_out,
  input  logic [USEDW_W-1:0]      fifo_usedw,
  output logic                    fifo_rd,
  output logic                    wr_ctrl_rdy,
  output logic                    busy,
  output logic [ADDR_W-1:0]       address,
  output logic [DATA_W-1:0]       writedata,
  output logic                    write,
  output logic [BURSTCOUNT_W-1:0] burstcount,
  input  logic                    waitrequest
);

  localparam int BPW   = DATA_W / 8;
  localparam int OFF_W = (BPW > 1) ? $clog2(BPW) : 0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BPW - 1));

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       word_addr_q, word_addr_d;   // next word to write, in words
  logic [ADDR_W-1:0]       remaining_q, remaining_d;   // words still owed for the packet
  logic [ADDR_W-1:0]       address_q, address_d;
  logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
  logic [BURSTCOUNT_W-1:0] beat_q, beat_d;

  logic [ADDR_W-1:0]       begin_al, end_al, word_cnt;
  logic [BURSTCOUNT_W-1:0] len_c;
  logic                    fill_ok, last_beat;

  // Sub-word address bits are dropped; an end at or below the begin gives zero words.
  assign begin_al = pkt_begin & ALIGN_MASK;
  assign end_al   = pkt_end & ALIGN_MASK;
  assign word_cnt = (end_al > begin_al) ? ((end_al - begin_al) >> OFF_W) : '0;

  assign len_c     = burst_len(64'(remaining_q), 64'(word_addr_q), 64'(MAX_BURST));
  assign fill_ok   = 64'(fifo_usedw) >= 64'(len_c);
  assign last_beat = (beat_q == (burstcount_q - BURSTCOUNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    remaining_d  = remaining_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    beat_d       = beat_q;
    unique case (state_q)
      IDLE: begin
        if (wr_ctrl) begin
          word_addr_d = begin_al >> OFF_W;
          remaining_d = word_cnt;
          state_d     = CALC;
        end
      end
      CALC: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (fill_ok) begin
          address_d    = word_addr_q << OFF_W;
          burstcount_d = len_c;
          beat_d       = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (!waitrequest) begin
          if (last_beat) begin
            remaining_d = remaining_q - ADDR_W'(burstcount_q);
            word_addr_d = word_addr_q + ADDR_W'(burstcount_q);
            state_d     = CALC;
          end else begin
            beat_d = beat_q + BURSTCOUNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!wr_ctrl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_addr_q  <= '0;
      remaining_q  <= '0;
      address_q    <= '0;
      burstcount_q <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      remaining_q  <= remaining_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      beat_q       <= beat_d;
    end
  end

  assign write       = (state_q == BURST);
  assign fifo_rd     = write & ~waitrequest;
  assign busy        = (state_q != IDLE);
  assign wr_ctrl_rdy = (state_q == DONE);
  assign address     = address_q;
  assign burstcount  = burstcount_q;
  // Show-ahead head is presented directly; zero outside a burst.
  assign writedata   = write ? fifo_out : '0;

endmodule
